fb_swap_ctrl: RTL and testbench

//  Sequencer for the dual-bank frame buffer between PPU and VGA. Turns the PPU pixel stream into

---
 rtl/fb_swap_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// Dual-bank frame buffer sequencer: PPU write addressing, back-bank steering, VGA read address, tear-free swap.
// Optional FB_SWAP_STATS_EN adds the saturating frames_dropped counter; otherwise it reads as 0.
`timescale 1ns/1ps

module fb_swap_ctrl #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144,
    parameter int AW     = 15
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ppu_px_valid,
    input  logic [1:0]    ppu_px_data,
    input  logic          ppu_vblank,
    input  logic [8:0]    vga_x,
    input  logic [8:0]    vga_y,
    output logic [AW-1:0] fb_wr_addr,
    output logic [1:0]    fb_wr_data,
    output logic          fb_wr_en0,
    output logic          fb_wr_en1,
    output logic [AW-1:0] fb_rd_addr,
    output logic          rd_sel,
    output logic          frame_pending,
    output logic [7:0]    frames_dropped
);

    localparam logic [AW-1:0] LAST_PX  = AW'(WIDTH * HEIGHT - 1);
    localparam logic [AW-1:0] WIDTH_AW = AW'(WIDTH);
    localparam logic [8:0]    WIDTH_C  = 9'(WIDTH);
    localparam logic [8:0]    HEIGHT_C = 9'(HEIGHT);

    typedef enum logic [1:0] {
        ST_RESYNC  = 2'd0,
        ST_FILL    = 2'd1,
        ST_PENDING = 2'd2,
        ST_SWAP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          vblank_q;
    logic          rd_sel_q, rd_sel_d;
    logic          pending_q, pending_d;
    logic          corrupt_q, corrupt_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]    wr_data_q, wr_data_d;
    logic          wr_en0_q, wr_en0_d;
    logic          wr_en1_q, wr_en1_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          vb_rise;
    logic          last_px;
    logic          drop_inc;

    assign vb_rise = ppu_vblank & ~vblank_q;
    assign last_px = ppu_px_valid && (cnt_q == LAST_PX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_sel_d  = rd_sel_q;
        pending_d = pending_q;
        corrupt_d = corrupt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en0_d  = 1'b0;
        wr_en1_d  = 1'b0;
        drop_inc  = 1'b0;

        case (state_q)
            ST_RESYNC: begin
                if (vb_rise) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                // A completing pixel beats a coincident vblank edge; otherwise a mid-frame edge restarts the frame.
                if (vb_rise && (cnt_q != '0) && !last_px) begin
                    cnt_d    = '0;
                    drop_inc = 1'b1;
                end else if (ppu_px_valid) begin
                    wr_addr_d = cnt_q;
                    wr_data_d = ppu_px_data;
                    wr_en0_d  = rd_sel_q;
                    wr_en1_d  = ~rd_sel_q;
                    if (last_px) begin
                        cnt_d     = '0;
                        state_d   = ST_PENDING;
                        pending_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (ppu_px_valid && !corrupt_q) begin
                    corrupt_d = 1'b1;
                    drop_inc  = 1'b1;
                end
                if (vga_y >= HEIGHT_C) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                rd_sel_d  = ~rd_sel_q;
                pending_d = 1'b0;
                cnt_d     = '0;
                corrupt_d = 1'b0;
                state_d   = corrupt_q ? ST_RESYNC : ST_FILL;
            end
            default: begin
                state_d = ST_RESYNC;
            end
        endcase
    end

    always_comb begin
        rd_addr_d = '0;
        if ((vga_x < WIDTH_C) && (vga_y < HEIGHT_C)) begin
            rd_addr_d = (AW'(vga_y) * WIDTH_AW) + AW'(vga_x);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_RESYNC;
            cnt_q     <= '0;
            vblank_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            pending_q <= 1'b0;
            corrupt_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en0_q  <= 1'b0;
            wr_en1_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vblank_q  <= ppu_vblank;
            rd_sel_q  <= rd_sel_d;
            pending_q <= pending_d;
            corrupt_q <= corrupt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en0_q  <= wr_en0_d;
            wr_en1_q  <= wr_en1_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign fb_wr_addr    = wr_addr_q;
    assign fb_wr_data    = wr_data_q;
    assign fb_wr_en0     = wr_en0_q;
    assign fb_wr_en1     = wr_en1_q;
    assign fb_rd_addr    = rd_addr_q;
    assign rd_sel        = rd_sel_q;
    assign frame_pending = pending_q;

`ifdef FB_SWAP_STATS_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign frames_dropped = drop_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign frames_dropped  = '0;
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: directed frames with a write scoreboard drained by a negedge monitor.
`timescale 1ns/1ps

module tb_fb_swap_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ppu_px_valid;
    logic [1:0]  ppu_px_data;
    logic        ppu_vblank;
    logic [8:0]  vga_x;
    logic [8:0]  vga_y;
    logic [14:0] fb_wr_addr;
    logic [1:0]  fb_wr_data;
    logic        fb_wr_en0;
    logic        fb_wr_en1;
    logic [14:0] fb_rd_addr;
    logic        rd_sel;
    logic        frame_pending;
    logic [7:0]  frames_dropped;

    always #5 Clk = ~Clk;

    fb_swap_ctrl #(.WIDTH(160), .HEIGHT(144), .AW(15)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ppu_px_valid   (ppu_px_valid),
        .ppu_px_data    (ppu_px_data),
        .ppu_vblank     (ppu_vblank),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .fb_wr_addr     (fb_wr_addr),
        .fb_wr_data     (fb_wr_data),
        .fb_wr_en0      (fb_wr_en0),
        .fb_wr_en1      (fb_wr_en1),
        .fb_rd_addr     (fb_rd_addr),
        .rd_sel         (rd_sel),
        .frame_pending  (frame_pending),
        .frames_dropped (frames_dropped)
    );

`ifdef FB_SWAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [14:0] addr;
        logic [1:0]  data;
        logic        bank;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_drop(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [1:0] pix(input int i);
        logic [14:0] a;
        a = 15'(i);
        return a[1:0] ^ a[5:4];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe(input int i, input bit wr, input bit bank);
        ppu_px_valid = 1'b1;
        ppu_px_data  = pix(i);
        if (wr) exp_q.push_back('{addr: 15'(i), data: pix(i), bank: bank});
        tick();
        ppu_px_valid = 1'b0;
    endtask

    task automatic frame(input int first, input int n, input bit bank);
        for (int i = first; i < first + n; i++) strobe(i, 1'b1, bank);
    endtask

    task automatic vb_pulse();
        ppu_vblank = 1'b1;
        tick();
        ppu_vblank = 1'b0;
        tick();
    endtask

    // Every write the DUT presents must match the oldest expected write.
    always @(negedge Clk) begin
        if (!Reset && (fb_wr_en0 || fb_wr_en1)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d en1/en0 %b%b, expected no write",
                         fb_wr_addr, fb_wr_en1, fb_wr_en0);
            end else begin
                mon_e = exp_q.pop_front();
                if ({fb_wr_addr, fb_wr_data, fb_wr_en1, fb_wr_en0} !==
                    {mon_e.addr, mon_e.data, mon_e.bank, ~mon_e.bank}) begin
                    n_bad++;
                    $display("FAIL write: got addr %0d data %0d en1/en0 %b%b, expected addr %0d data %0d bank %0d",
                             fb_wr_addr, fb_wr_data, fb_wr_en1, fb_wr_en0, mon_e.addr, mon_e.data, mon_e.bank);
                end
                n_cmp++;
                if (rd_sel !== ~mon_e.bank) begin
                    n_bad++;
                    $display("FAIL write_vs_rd_sel: got rd_sel %0d, expected %0d", rd_sel, ~mon_e.bank);
                end
            end
        end
    end

    initial begin
        Reset        = 1'b1;
        ppu_px_valid = 1'b0;
        ppu_px_data  = 2'd0;
        ppu_vblank   = 1'b0;
        vga_x        = 9'd0;
        vga_y        = 9'd50;
        tick();
        tick();
        check("rst_rd_sel", rd_sel, 0);
        check("rst_pending", frame_pending, 0);
        check("rst_dropped", frames_dropped, 0);
        check("rst_wr_en0", fb_wr_en0, 0);
        check("rst_wr_en1", fb_wr_en1, 0);
        check("rst_wr_addr", fb_wr_addr, 0);
        check("rst_rd_addr", fb_rd_addr, 0);
        Reset = 1'b0;

        // Pixels before the first vblank edge are ignored.
        for (int i = 0; i < 5; i++) strobe(i, 1'b0, 1'b0);
        check("presync_dropped", frames_dropped, 0);

        // Frame A to bank 1, then three strobes while pending.
        vb_pulse();
        frame(0, 23040, 1'b1);
        tick();
        check("a_pending", frame_pending, 1);
        check("a_rd_sel", rd_sel, 0);
        check("a_writes_drained", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) strobe(i, 1'b0, 1'b0);
        tick();
        check("corrupt_dropped", frames_dropped, exp_drop(1));
        check("corrupt_pending", frame_pending, 1);
        vga_y = 9'd144;
        tick();
        check("swap_cycle_rd_sel", rd_sel, 0);
        check("swap_cycle_pending", frame_pending, 1);
        tick();
        check("a_swap_rd_sel", rd_sel, 1);
        check("a_swap_pending", frame_pending, 0);
        vga_y = 9'd50;

        // Corrupt swap lands in resync: no writes until the next vblank edge.
        for (int i = 0; i < 5; i++) strobe(i, 1'b0, 1'b0);
        check("resync_dropped", frames_dropped, exp_drop(1));

        // Short frame then full frame B to bank 0.
        vb_pulse();
        frame(0, 10000, 1'b0);
        vb_pulse();
        check("short_dropped", frames_dropped, exp_drop(2));
        frame(0, 23040, 1'b0);
        tick();
        check("b_pending", frame_pending, 1);
        check("b_rd_sel", rd_sel, 1);
        check("b_dropped", frames_dropped, exp_drop(2));

        // Reset while pending.
        Reset = 1'b1;
        tick();
        check("prst_rd_sel", rd_sel, 0);
        check("prst_pending", frame_pending, 0);
        check("prst_dropped", frames_dropped, 0);
        check("prst_wr_en", {fb_wr_en1, fb_wr_en0}, 0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) strobe(i, 1'b0, 1'b0);

        // Frame C to bank 1; last pixel coincides with a vblank edge.
        vb_pulse();
        frame(0, 23039, 1'b1);
        ppu_vblank = 1'b1;
        strobe(23039, 1'b1, 1'b1);
        ppu_vblank = 1'b0;
        tick();
        check("c_pending", frame_pending, 1);
        check("c_dropped", frames_dropped, 0);
        check("c_rd_sel", rd_sel, 0);
        vga_y = 9'd144;
        tick();
        tick();
        check("c_swap_rd_sel", rd_sel, 1);
        check("c_swap_pending", frame_pending, 0);
        vga_y = 9'd50;
        strobe(0, 1'b1, 1'b0);
        tick();
        check("c_writes_drained", exp_q.size(), 0);

        // Read address path.
        vga_x = 9'd159; vga_y = 9'd143; tick();
        check("rd_last", fb_rd_addr, 23039);
        vga_x = 9'd160; tick();
        check("rd_x_oob", fb_rd_addr, 0);
        vga_x = 9'd5; vga_y = 9'd2; tick();
        check("rd_mid", fb_rd_addr, 325);
        vga_x = 9'd0; vga_y = 9'd144; tick();
        check("rd_y_oob", fb_rd_addr, 0);
        vga_x = 9'd159; vga_y = 9'd0; tick();
        check("rd_row0_end", fb_rd_addr, 159);

        tick();
        check("final_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
